// File: rtl/branch_pkg.sv
// Shared definitions for the branch compare pipeline.
//   branch_op_e : RISC-V branch funct3 encodings (BEQ..BGEU), typed on 3 bits.
//                 funct3 values 010 and 011 have no member and decode as illegal.
//   RES_W       : width of the packed result {taken, equal, less, illegal}.
package branch_pkg;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } branch_op_e;

    localparam int RES_W = 4;

endpackage

// File: rtl/brc_core.sv
// Combinational branch comparator.
//   a, b    : operands (WIDTH bits)
//   funct3  : RISC-V branch funct3
//   taken   : branch decision (0 for illegal funct3)
//   equal   : a == b
//   less    : a < b, signed when funct3[1]==0, unsigned otherwise
//   illegal : funct3 is 010 or 011
module brc_core
    import branch_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       funct3,
    output logic             taken,
    output logic             equal,
    output logic             less,
    output logic             illegal
);

    // One extra bit of subtraction: sign-extend for signed mode, zero-extend
    // for unsigned mode; the extra bit of the difference is then "a < b"
    // in either mode, overflow included.
    logic             sext;
    logic [WIDTH:0]   diff;

    assign sext  = ~funct3[1];
    assign diff  = {sext & a[WIDTH-1], a} - {sext & b[WIDTH-1], b};
    // a - b is zero modulo 2^WIDTH exactly when a == b.
    assign equal = (diff[WIDTH-1:0] == '0);
    assign less  = diff[WIDTH];

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            BEQ:        taken = equal;
            BNE:        taken = ~equal;
            BLT, BLTU:  taken = less;
            BGE, BGEU:  taken = ~less;
            default:    illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_cmp_pipe.sv
// Pipelined branch comparator with valid/ready handshakes on both sides.
// The compare is done combinationally ahead of stage 1; stages 1..LATENCY
// only carry the result bits and tag. Each stage loads when empty or when
// the stage after it moves on, so bubbles collapse under backpressure.
//   i_clk, i_reset (async, active-high), i_flush (sync, kills in-flight work)
//   i_valid/o_ready        : request handshake
//   i_rs1_data, i_rs2_data : operands; i_funct3 : branch type; i_tag : sideband
//   o_valid/i_ready        : result handshake
//   o_taken, o_equal, o_less, o_illegal, o_tag : result, all 0 when !o_valid
module branch_cmp_pipe
    import branch_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2,
    parameter int TAG_W   = 5
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_rs1_data,
    input  logic [WIDTH-1:0] i_rs2_data,
    input  logic [2:0]       i_funct3,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_taken,
    output logic             o_equal,
    output logic             o_less,
    output logic             o_illegal,
    output logic [TAG_W-1:0] o_tag
);

    logic             core_taken, core_equal, core_less, core_illegal;
    logic [RES_W-1:0] core_res;

    brc_core #(.WIDTH(WIDTH)) u_core (
        .a       (i_rs1_data),
        .b       (i_rs2_data),
        .funct3  (i_funct3),
        .taken   (core_taken),
        .equal   (core_equal),
        .less    (core_less),
        .illegal (core_illegal)
    );

    assign core_res = {core_taken, core_equal, core_less, core_illegal};

    logic             vld [1:LATENCY];
    logic [RES_W-1:0] res [1:LATENCY];
    logic [TAG_W-1:0] tag [1:LATENCY];
    logic [LATENCY+1:1] ld;   // ld[s]: stage s loads at the next edge

    // Ready ripples back from the output: a stage can take new data when it
    // is empty or everything after it is moving.
    always_comb begin
        ld = '0;
        ld[LATENCY+1] = i_ready;
        for (int s = LATENCY; s >= 1; s--)
            ld[s] = ~vld[s] | ld[s+1];
    end

    for (genvar s = 1; s <= LATENCY; s++) begin : g_stage
        logic             v_in;
        logic [RES_W-1:0] r_in;
        logic [TAG_W-1:0] t_in;

        if (s == 1) begin : g_head
            assign v_in = i_valid;
            assign r_in = core_res;
            assign t_in = i_tag;
        end else begin : g_body
            assign v_in = vld[s-1];
            assign r_in = res[s-1];
            assign t_in = tag[s-1];
        end

        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                vld[s] <= 1'b0;
                res[s] <= '0;
                tag[s] <= '0;
            end else if (i_flush) begin
                vld[s] <= 1'b0;
            end else if (ld[s]) begin
                vld[s] <= v_in;
                if (v_in) begin
                    res[s] <= r_in;
                    tag[s] <= t_in;
                end
            end
        end
    end

    assign o_ready = ld[1];
    assign o_valid = vld[LATENCY];
    // Stage data is stale after a flush or drain, so gate it with o_valid.
    assign {o_taken, o_equal, o_less, o_illegal} = o_valid ? res[LATENCY] : '0;
    assign o_tag = o_valid ? tag[LATENCY] : '0;

endmodule
